// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with IMEM handshake, HALT and fetch timeout.
// Optional retired-instruction counter enabled by defining CPU_SEQ_CTRL_PERF_EN.
module cpu_seq_ctrl #(
   parameter int             OPW           = 5,
   parameter logic [OPW-1:0] HALT_OP       = '1,
   parameter logic [OPW-1:0] NOP_OP        = '0,
   parameter int             FETCH_TIMEOUT = 8,
   parameter int             CNTW          = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic            imem_ack,
   input  logic [OPW-1:0]  opcode,
   output logic            imem_req,
   output logic            ir_load,
   output logic            reg_write,
   output logic            pc_en,
   output logic            halted,
   output logic            fault,
   output logic [2:0]      state,
   output logic [CNTW-1:0] retired_cnt
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   // Counter only needs to reach FETCH_TIMEOUT-1; keep at least one bit when disabled.
   localparam int             TW      = (FETCH_TIMEOUT >= 2) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [TW-1:0]  TO_LAST = TW'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

   state_t           r_state;
   state_t           w_next;
   logic [TW-1:0]    r_to_cnt;
   logic [OPW-1:0]   r_op_q;
   logic             w_timeout;

   assign w_timeout = (FETCH_TIMEOUT != 0) && (r_to_cnt == TO_LAST);
   assign state     = r_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_to_cnt <= '0;
         r_op_q   <= '0;
      end else begin
         r_state  <= w_next;
         r_to_cnt <= (r_state == S_FETCH && !imem_ack) ? r_to_cnt + TW'(1) : '0;
         if (r_state == S_DECODE)
            r_op_q <= opcode;
      end
   end

   always_comb begin
      w_next    = r_state;
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run)
               w_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ack;
            // An ack on the limit cycle takes priority over the timeout.
            if (imem_ack)
               w_next = S_DECODE;
            else if (w_timeout)
               w_next = S_FAULT;
         end
         S_DECODE: begin
            w_next = (opcode == HALT_OP) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            w_next = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            pc_en     = 1'b1;
            reg_write = (r_op_q != NOP_OP);
            w_next    = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

`ifdef CPU_SEQ_CTRL_PERF_EN
   logic [CNTW-1:0] r_retired_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_retired_cnt <= '0;
      else if (r_state == S_WRITEBACK)
         r_retired_cnt <= r_retired_cnt + CNTW'(1);
   end

   assign retired_cnt = r_retired_cnt;
`else
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl; counter checks follow CPU_SEQ_CTRL_PERF_EN.
`timescale 1ns/1ps
module tb_cpu_seq_ctrl;

   localparam int CNTW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            run;
   logic            imem_ack;
   logic [4:0]      opcode;
   logic            imem_req;
   logic            ir_load;
   logic            reg_write;
   logic            pc_en;
   logic            halted;
   logic            fault;
   logic [2:0]      state;
   logic [CNTW-1:0] retired_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_ret  = 0;

   cpu_seq_ctrl #(
      .OPW(5), .HALT_OP(5'b11111), .NOP_OP(5'b00000), .FETCH_TIMEOUT(8), .CNTW(CNTW)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .imem_ack(imem_ack), .opcode(opcode),
      .imem_req(imem_req), .ir_load(ir_load), .reg_write(reg_write), .pc_en(pc_en),
      .halted(halted), .fault(fault), .state(state), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef CPU_SEQ_CTRL_PERF_EN
      return 32'(exp_ret % (1 << CNTW));
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk_outs(input string tag, input int st, input logic req, input logic irl,
                           input logic rw, input logic pce, input logic hlt, input logic flt);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".imem_req"}, 32'(imem_req), 32'(req));
      chk({tag, ".ir_load"}, 32'(ir_load), 32'(irl));
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
      chk({tag, ".pc_en"}, 32'(pc_en), 32'(pce));
      chk({tag, ".halted"}, 32'(halted), 32'(hlt));
      chk({tag, ".fault"}, 32'(fault), 32'(flt));
   endtask

   // Called at a FETCH-cycle negedge with ack=1; walks one instruction to the next FETCH.
   task automatic one_instr(input string tag, input logic [4:0] op, input logic exp_rw);
      opcode = op;
      chk_outs({tag, ".F"}, 1, 1, 1, 0, 0, 0, 0);
      tick();
      chk_outs({tag, ".D"}, 2, 0, 0, 0, 0, 0, 0);
      tick();
      chk_outs({tag, ".E"}, 3, 0, 0, 0, 0, 0, 0);
      tick();
      chk_outs({tag, ".W"}, 4, 0, 0, exp_rw, 1, 0, 0);
      tick();
      exp_ret++;
      chk({tag, ".retired"}, 32'(retired_cnt), exp_cnt());
   endtask

   task automatic do_reset();
      run = 1'b0; imem_ack = 1'b0; opcode = '0;
      reset = 1'b0;
      tick();
      exp_ret = 0;
      chk_outs("rst", 0, 0, 0, 0, 0, 0, 0);
      chk("rst.retired", 32'(retired_cnt), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; run = 1'b0; imem_ack = 1'b0; opcode = '0;
      @(negedge clk);
      do_reset();

      // Zero-wait stream of opcode 00001.
      run = 1'b1; imem_ack = 1'b1; opcode = 5'b00001;
      tick();
      for (int i = 0; i < 3; i++) one_instr("stream", 5'b00001, 1'b1);

      // NOP retires without register write, then a normal op.
      one_instr("nop", 5'b00000, 1'b0);
      one_instr("op2", 5'b00010, 1'b1);

      // run dropped during EXECUTE: WRITEBACK still happens, then IDLE.
      opcode = 5'b00011;
      tick();
      tick();
      chk("stop.E.state", 32'(state), 32'd3);
      run = 1'b0;
      tick();
      chk_outs("stop.W", 4, 0, 0, 1, 1, 0, 0);
      tick();
      exp_ret++;
      chk_outs("stop.I", 0, 0, 0, 0, 0, 0, 0);
      chk("stop.retired", 32'(retired_cnt), exp_cnt());
      tick();
      chk("stop.I2.state", 32'(state), 32'd0);
      run = 1'b1;
      tick();
      chk("restart.state", 32'(state), 32'd1);

      // HALT is sticky and ignores run.
      opcode = 5'b11111;
      tick();
      chk("halt.D.state", 32'(state), 32'd2);
      tick();
      chk_outs("halt.H", 5, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 20; i++) begin
         run = i[0];
         tick();
         chk("halt.loop.state", 32'(state), 32'd5);
         chk("halt.loop.halted", 32'(halted), 32'd1);
         chk("halt.loop.pc_en", 32'(pc_en), 32'd0);
      end
      chk("halt.retired", 32'(retired_cnt), exp_cnt());
      #2 reset = 1'b0;
      #1;
      chk("halt.arst.state", 32'(state), 32'd0);
      chk("halt.arst.halted", 32'(halted), 32'd0);
      @(negedge clk);
      do_reset();

      // No ack for 8 FETCH cycles -> FAULT.
      run = 1'b1; imem_ack = 1'b0;
      tick();
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("to.wait.state", 32'(state), 32'd1);
      end
      tick();
      chk_outs("to.fault", 6, 0, 0, 0, 0, 0, 1);
      run = 1'b0;
      tick();
      chk("to.sticky.state", 32'(state), 32'd6);
      do_reset();

      // Ack on the 8th FETCH cycle wins over the timeout.
      run = 1'b1; imem_ack = 1'b0; opcode = 5'b00001;
      tick();
      for (int i = 1; i < 8; i++) tick();
      chk("late.F8.state", 32'(state), 32'd1);
      imem_ack = 1'b1;
      #1 chk("late.ir_load", 32'(ir_load), 32'd1);
      tick();
      chk("late.D.state", 32'(state), 32'd2);
      chk("late.D.fault", 32'(fault), 32'd0);
      do_reset();

      // 17 retirements wrap a 4-bit counter to 1.
      run = 1'b1; imem_ack = 1'b1;
      tick();
      for (int i = 0; i < 17; i++) one_instr("wrap", 5'b00100, 1'b1);
`ifdef CPU_SEQ_CTRL_PERF_EN
      chk("wrap.retired", 32'(retired_cnt), 32'd1);
`else
      chk("wrap.retired", 32'(retired_cnt), 32'd0);
`endif
      // Asynchronous reset in the middle of FETCH.
      chk("arst.pre.imem_req", 32'(imem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst.imem_req", 32'(imem_req), 32'd0);
      chk("arst.state", 32'(state), 32'd0);
      chk("arst.retired", 32'(retired_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle control sequencer for the 16-bit single-issue CPU datapath (IMEM, decoder, register file, ALU, PC adder). It replaces the free-running PC update and the permanently asserted register-file write enable with a FETCH/DECODE/EXECUTE/WRITEBACK state machine. It also adds a request/acknowledge handshake to instruction memory, a HALT opcode and a fetch-timeout fault.

Parameters:
OPW, 5, opcode width (instruction[15:11])
HALT_OP, 5'b11111, opcode that stops the machine
NOP_OP, 5'b00000, opcode that retires without a register write
FETCH_TIMEOUT, 8, maximum FETCH cycles without imem_ack before FAULT; 0 disables the timeout
CNTW, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = execute, 0 = stop after the current instruction
imem_ack  in  1  instruction word valid on the IMEM output this cycle
opcode  in  OPW  instruction[15:11] from the instruction register
imem_req  out  1  fetch request to IMEM
ir_load  out  1  load the instruction register
reg_write  out  1  register-file write enable
pc_en  out  1  load pc with next_pc
halted  out  1  HALT opcode reached
fault  out  1  fetch timeout occurred
state  out  3  current state encoding, for debug
retired_cnt  out  CNTW  instructions retired (optional feature only)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0, latched opcode=0.
  - All outputs 0; retired_cnt=0.
  - Reset is honoured in every state, including mid-fetch, HALT and FAULT.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, FAULT=6.
- Output timing: Moore outputs decoded from the registered state, except ir_load (see FETCH).
- IDLE: all outputs 0. run=1 -> FETCH on the next edge; otherwise remain in IDLE.
- FETCH:
  - imem_req=1.
  - ir_load = imem_ack (combinational, asserted in the same cycle as the ack).
  - imem_ack=1 -> DECODE; timeout counter cleared.
  - imem_ack=0 -> counter increments. When FETCH_TIMEOUT!=0 and the counter equals FETCH_TIMEOUT-1 with no ack -> FAULT.
  - An ack in the same cycle as the timeout limit wins: go to DECODE, not FAULT.
  - run is ignored while in FETCH; an outstanding fetch always completes.
- DECODE:
  - Latch opcode into op_q.
  - op_q source == HALT_OP -> HALT; otherwise -> EXECUTE.
  - No enables asserted.
- EXECUTE: exactly one cycle for ALU settling; no enables; -> WRITEBACK.
- WRITEBACK:
  - pc_en=1.
  - reg_write=1 unless op_q==NOP_OP.
  - Next state: run=1 -> FETCH, run=0 -> IDLE.
  - Each instruction retires here.
- Throughput: 4 cycles per instruction with zero-wait IMEM (FETCH, DECODE, EXECUTE, WRITEBACK). Each IMEM wait cycle adds one.
- HALT:
  - halted=1; pc_en=0, so pc keeps the HALT address; reg_write=0.
  - Sticky until reset; run has no effect.
- FAULT: fault=1, all enables 0, sticky until reset.
- Unused encoding 7 -> IDLE on the next edge, with outputs 0.
- Ordering guarantee: reg_write and pc_en are never high outside WRITEBACK; imem_req is never high outside FETCH.

Optional Feature:
- Macro CPU_SEQ_CTRL_PERF_EN defined:
  - retired_cnt increments by 1 on every WRITEBACK cycle.
  - Wraps from 2^CNTW-1 to 0.
  - Cleared only by reset.
  - HALT is not counted.
- Macro undefined: retired_cnt is tied to 0 and no counter flops are built.

Test Plan:
1. Reset, run=1, imem_ack tied 1, opcodes 00001 repeated: state sequence 1,2,3,4,1... One pc_en and one reg_write pulse every 4 cycles; ir_load high in each FETCH cycle.
2. Opcode NOP_OP=00000 followed by 00010: first WRITEBACK has pc_en=1 and reg_write=0; second has both =1.
3. Opcode 11111 fetched: DECODE -> HALT; halted=1 and pc_en stays 0 for 20 cycles with run toggling. Assert reset=0 -> state=0, halted=0.
4. imem_ack held 0 for 8 FETCH cycles (FETCH_TIMEOUT=8): fault=1 and state=6. Repeat with the ack arriving on the 8th cycle: DECODE is entered and fault stays 0.
5. Drop run to 0 during EXECUTE: WRITEBACK still completes with pc_en=1, then IDLE. Raise run to 1: FETCH on the next cycle.
6. With CPU_SEQ_CTRL_PERF_EN defined and CNTW=4: after 17 retired instructions retired_cnt=1 (wrap). Assert reset mid-FETCH -> retired_cnt=0 and imem_req=0 immediately, without waiting for a clock edge.
